// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw button levels in, conditioned level and event pulses out.
interface key_conditioner_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    // Board / stimulus side: drives raw buttons, consumes events.
    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_long
    );

    // Conditioner side.
    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_long
    );
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner: per-key 2-flop synchroniser, debounce FSM and long-press
// detector. Channels are independent lanes; all outputs are registered.

// One debounced key channel, fed by an already-synchronised level.
module key_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Next-state, counters and the pulses to be registered on this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        fired_d   = fired_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    hold_d  = '0;
                    fired_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Hold counts every PRESSED cycle, including the one that
                // sees the release start; it stops only in RELEASE_WAIT.
                if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_MAX && !fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin // RELEASE_WAIT, hold frozen
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    hold_d    = '0;
                    fired_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // Channel state and registered outputs; reset drops everything silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
endmodule

module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic               clk,
    input  logic               reset,
    key_conditioner_if.slave   kif
);
    logic [N_KEYS-1:0] meta_q, sync_q;
    logic [N_KEYS-1:0] level_w, press_w, release_w, long_w;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= kif.key_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_lane
        key_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .s           (sync_q[k]),
            .key_level   (level_w[k]),
            .key_press   (press_w[k]),
            .key_release (release_w[k]),
            .key_long    (long_w[k])
        );
    end

    assign kif.key_level   = level_w;
    assign kif.key_press   = press_w;
    assign kif.key_release = release_w;
    assign kif.key_long    = long_w;
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-conditioning stage directly upstream of the washing-machine controller top level. It takes the raw board buttons (power, start/pause, model select, clothes add), synchronises them to `clk`, and debounces each one independently. Per key it produces a clean level, a one-cycle press pulse, a one-cycle release pulse and a one-cycle long-press pulse. The controller consumes the press pulses in place of its raw `reset`/`start`/`model_choose`/`clothes_add` inputs and no longer needs its own edge-detect flags.

## Interface
- `N_KEYS`, 4, number of key channels; bit 0 power, bit 1 start/pause, bit 2 model select, bit 3 clothes add.
- `DEBOUNCE_CYCLES`, 1_000_000, stable-sample count required to accept a transition (10 ms at 100 MHz); must be ≥ 2.
- `LONG_CYCLES`, 200_000_000, held cycles after an accepted press before `key_long` fires (2 s); must be ≥ 2.
- Counter widths are `$clog2` of the respective parameter. No other width parameters.
- `clk` input 1: 100 MHz system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `key_raw` input N_KEYS: raw button levels, active-high, asynchronous to `clk`.
- `key_level` output N_KEYS: debounced level, 1 = pressed.
- `key_press` output N_KEYS: one-cycle pulse on each accepted press.
- `key_release` output N_KEYS: one-cycle pulse on each accepted release.
- `key_long` output N_KEYS: one-cycle pulse, at most once per press, when a hold reaches `LONG_CYCLES`.

## Operation
- Each channel has a 2-flop synchroniser. Its output is `s`. Every channel logic below uses only `s`.
- Each channel has its own FSM (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), a debounce counter `cnt` and a hold counter `hold`. Channels are fully independent.
- **IDLE:** `key_level=0`. On `s=1`, go to PRESS_WAIT with `cnt=1`.
- **PRESS_WAIT:**
  - On `s=0`, return to IDLE with `cnt=0`. No output.
  - Otherwise, if `cnt==DEBOUNCE_CYCLES-1`, go to PRESSED, pulse `key_press`, clear `hold`.
  - Otherwise, increment `cnt`.
- **PRESSED:** `key_level=1`.
  - `hold` increments each cycle and saturates at `LONG_CYCLES-1`.
  - The cycle `hold` reaches `LONG_CYCLES-1`, pulse `key_long`. It does not pulse again for this press.
  - On `s=0`, go to RELEASE_WAIT with `cnt=1`.
- **RELEASE_WAIT:** `key_level` stays 1 and `hold` is frozen.
  - On `s=1`, return to PRESSED. `hold` resumes and no new press pulse is issued.
  - Otherwise, if `cnt==DEBOUNCE_CYCLES-1`, go to IDLE, pulse `key_release`, clear `hold`.
  - Otherwise, increment `cnt`.
- All outputs are registered.
- `key_level` is 1 exactly in PRESSED and RELEASE_WAIT, and changes on the same edge as the corresponding pulse.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles of `s` in either direction produce no output change.
- Simultaneous events on different channels are reported in the same cycle. There is no arbitration or priority.

## Timing
- **Reset values:** while `reset=0`, all synchroniser flops, FSMs (IDLE), counters and outputs are 0. This takes effect immediately (asynchronous).
- **Reset mid-operation:** state is discarded with no release pulse. If a key is still held after `reset` deasserts, it is treated as a fresh press and pulses `key_press` after the normal latency.
- **Press latency:** if `key_raw` rises and is first sampled at edge E1, `key_press` and `key_level` go high on edge E(DEBOUNCE_CYCLES+2).
  - Release latency is the same, measured from the first sampled low edge.
- **Long press:** `key_long` is registered LONG_CYCLES edges after the `key_press` edge, provided there is no RELEASE_WAIT time in between. Cycles spent in RELEASE_WAIT extend this.
- **Pulse widths:** each pulse is exactly 1 cycle.
  - `key_press` and `key_release` of one channel are never closer than DEBOUNCE_CYCLES cycles apart.
  - `key_long` never coincides with `key_release`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=10`.
- **Reset:** hold `reset=0` with `key_raw=4'hF` → all outputs 0. Release reset with keys held → all four `key_press` bits pulse together 6 edges after the first sampling edge, and `key_level=4'hF`.
- **Clean press:** hold `key_raw[1]` high for 8 cycles, then low.
  - `key_press=4'b0010` for 1 cycle at E6.
  - `key_level[1]` high from E6.
  - `key_release[1]` pulses 6 edges after the first low sample; `key_long` stays 0.
- **Bounce:** drive `key_raw[2]` 1,1,0,1,1,1,0 then steady 1 → no output until the steady run reaches 4 synchronised samples, then exactly one `key_press[2]`. Repeat on release with 3-cycle low glitches → no `key_release` until a 4-sample low run.
- **Long press:** hold `key_raw[3]` for 30 cycles → one `key_press[3]`, one `key_long[3]` exactly 10 edges later, no second `key_long`, then `key_release[3]` after release debounce.
- **Release glitch during hold:** in PRESSED, drop `key_raw[0]` for 2 cycles → `key_level[0]` stays 1, no pulses, `key_long` delayed by the cycles spent in RELEASE_WAIT.
- **Reset while pressed:** assert `reset` while channel 1 is in PRESSED → `key_level` drops to 0 immediately with no `key_release`. With the key still held after deassert → a new `key_press[1]` at E6.
